// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, ownership-locked arbiter sharing one memory port between parser (0) and loader (1).
// Optional MEM_ARB_STATS_EN adds grant and conflict counters.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WIDTH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_ce_i,
  input  logic               req0_we_i,
  input  logic [ADDR_W-1:0]  req0_addr_i,
  input  logic [WIDTH_W-1:0] req0_width_i,
  input  logic [DATA_W-1:0]  req0_data_i,
  output logic               req0_gnt_o,
  input  logic               req1_ce_i,
  input  logic               req1_we_i,
  input  logic [ADDR_W-1:0]  req1_addr_i,
  input  logic [WIDTH_W-1:0] req1_width_i,
  input  logic [DATA_W-1:0]  req1_data_i,
  output logic               req1_gnt_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               mem_ce_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [WIDTH_W-1:0] mem_width_o,
  output logic [DATA_W-1:0]  mem_data_o,
  input  logic [DATA_W-1:0]  mem_data_i
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]        gnt0_cnt_o,
  output logic [31:0]        gnt1_cnt_o,
  output logic [31:0]        conflict_cnt_o
`endif
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic rr_last, rr_last_nx;
  logic sel0, sel1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nx;
      rr_last <= rr_last_nx;
    end
  end
  always_comb begin
    state_nx   = state;
    rr_last_nx = rr_last;
    case (state)
      IDLE: state_nx = (req0_ce_i && req1_ce_i) ? (rr_last ? OWN0 : OWN1) :
                       req0_ce_i ? OWN0 : req1_ce_i ? OWN1 : IDLE;
      OWN0: if (!req0_ce_i) begin
        state_nx   = req1_ce_i ? OWN1 : IDLE;
        rr_last_nx = 1'b0;
      end
      OWN1: if (!req1_ce_i) begin
        state_nx   = req0_ce_i ? OWN0 : IDLE;
        rr_last_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign sel0       = state == OWN0;
  assign sel1       = state == OWN1;
  assign req0_gnt_o = sel0;
  assign req1_gnt_o = sel1;
  assign rdata_o    = mem_data_i;
  // Memory port follows the owner combinationally so address walks reach memory in the same cycle.
  assign mem_ce_o    = sel0 ? req0_ce_i    : sel1 ? req1_ce_i    : 1'b0;
  assign mem_we_o    = sel0 ? req0_we_i    : sel1 ? req1_we_i    : 1'b0;
  assign mem_addr_o  = sel0 ? req0_addr_i  : sel1 ? req1_addr_i  : '0;
  assign mem_width_o = sel0 ? req0_width_i : sel1 ? req1_width_i : '0;
  assign mem_data_o  = sel0 ? req0_data_i  : sel1 ? req1_data_i  : '0;
`ifdef MEM_ARB_STATS_EN
  logic conflict;
  assign conflict = (sel0 && req1_ce_i) || (sel1 && req0_ce_i) ||
                    (state == IDLE && req0_ce_i && req1_ce_i);
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_cnt_o     <= '0;
      gnt1_cnt_o     <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (state_nx == OWN0 && !sel0) gnt0_cnt_o <= gnt0_cnt_o + 32'd1;
      if (state_nx == OWN1 && !sel1) gnt1_cnt_o <= gnt1_cnt_o + 32'd1;
      if (conflict) conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif
endmodule
